vga_rect_scheduler: RTL and testbench

Shares the pixel-plot port of the VGA adapter between two rectangle-drawing requesters. Each requester hands over one filled-rectangle command through a valid/ready handshake. The block arbitrates round-robin, rasterises the winning command one pixel per clock onto `x`/`y`/`colour`/`plot`, and clips against the screen. It sits between the game logic and the VGA adapter's `x`, `y`, `colour` and `plot` inputs.

---
 rtl/vga_rect_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_vga_rect_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_scheduler.sv
// rtl/vga_rect_scheduler.sv - round-robin filled-rectangle rasteriser sharing the VGA plot port
// Optional: define VGA_RECT_SCHED_CLEAR_ON_RESET_EN to blank the screen after reset.
module vga_rect_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [10:0] req0_x,
  input  logic [10:0] req0_y,
  input  logic [7:0]  req0_w,
  input  logic [7:0]  req0_h,
  input  logic [2:0]  req0_colour,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [10:0] req1_x,
  input  logic [10:0] req1_y,
  input  logic [7:0]  req1_w,
  input  logic [7:0]  req1_h,
  input  logic [2:0]  req1_colour,
  output logic        done0,
  output logic        done1,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy
);
  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] SH = 11'(SCREEN_H);

`ifdef VGA_RECT_SCHED_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE, S_CLEAR} state_t;
  localparam state_t S_RESET = S_CLEAR;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t      state_q, state_d;
  logic        last_q, last_d, owner_q, owner_d;
  logic [10:0] bx_q, bx_d, by_q, by_d;
  logic [7:0]  w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [2:0]  fill_q, fill_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, done0_q, done0_d, done1_q, done1_d;
  logic        grant0, grant1;
  logic [7:0]  col_nx, row_nx, sel_w, sel_h;
  logic [10:0] px, py, sel_x, sel_y;

  // last_q == 1 means requester 1 won the previous grant, so requester 0 wins a tie
  assign grant0 = (state_q == S_IDLE) && !reset && req0_valid && (!req1_valid || last_q);
  assign grant1 = (state_q == S_IDLE) && !reset && req1_valid && (!req0_valid || !last_q);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_x = grant1 ? req1_x : req0_x;
  assign sel_y = grant1 ? req1_y : req0_y;
  assign sel_w = grant1 ? req1_w : req0_w;
  assign sel_h = grant1 ? req1_h : req0_h;

  assign col_nx = (col_q == w_q - 8'd1) ? 8'd0 : col_q + 8'd1;
  assign row_nx = (col_q == w_q - 8'd1) ? row_q + 8'd1 : row_q;
  assign px     = bx_q + {3'b000, col_nx};
  assign py     = by_q + {3'b000, row_nx};

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    bx_d     = bx_q;
    by_d     = by_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    row_d    = row_q;
    fill_d   = fill_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          last_d  = grant1;
          bx_d    = sel_x;
          by_d    = sel_y;
          w_d     = sel_w;
          h_d     = sel_h;
          fill_d  = grant1 ? req1_colour : req0_colour;
          col_d   = 8'd0;
          row_d   = 8'd0;
          if (sel_w == 8'd0 || sel_h == 8'd0) begin
            state_d = S_DONE;
            done0_d = grant0;
            done1_d = grant1;
          end else begin
            // first pixel is registered at the accept edge so it shows in cycle 1
            state_d  = S_DRAW;
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = grant1 ? req1_colour : req0_colour;
            plot_d   = (sel_x < SW) && (sel_y < SH);
          end
        end
      end
      S_DRAW: begin
        if (col_q == w_q - 8'd1 && row_q == h_q - 8'd1) begin
          state_d = S_DONE;
          done0_d = !owner_q;
          done1_d = owner_q;
        end else begin
          col_d    = col_nx;
          row_d    = row_nx;
          x_d      = px;
          y_d      = py;
          colour_d = fill_q;
          plot_d   = (px < SW) && (py < SH);
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef VGA_RECT_SCHED_CLEAR_ON_RESET_EN
      S_CLEAR: begin
        colour_d = 3'd0;
        // sweep position lives in x_q/y_q; plot_q low marks the sweep has not started
        if (plot_q && x_q == SW - 11'd1 && y_q == SH - 11'd1) begin
          state_d = S_IDLE;
        end else begin
          plot_d = 1'b1;
          if (!plot_q) begin
            x_d = 11'd0;
            y_d = 11'd0;
          end else if (x_q == SW - 11'd1) begin
            x_d = 11'd0;
            y_d = y_q + 11'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      bx_q     <= '0;
      by_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fill_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fill_q   <= fill_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// tb/tb_vga_rect_scheduler.sv - directed, table-driven bench for vga_rect_scheduler
module tb_vga_rect_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [10:0] req0_x, req0_y, req1_x, req1_y;
  logic [7:0]  req0_w, req0_h, req1_w, req1_h;
  logic [2:0]  req0_colour, req1_colour;
  logic        done0, done1, plot, busy;
  logic [10:0] x, y;
  logic [2:0]  colour;

  int errors = 0;
  int checks = 0;

  vga_rect_scheduler #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_w(req0_w), .req0_h(req0_h), .req0_colour(req0_colour),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_w(req1_w), .req1_h(req1_h), .req1_colour(req1_colour),
    .done0(done0), .done1(done1), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int sel, rx, ry, rw, rh, rc;
    int exp_plots, exp_done, fx, fy, lx, ly;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int sel, input int rx, input int ry, input int rw, input int rh, input int rc);
    if (sel == 0) begin
      req0_x = 11'(rx); req0_y = 11'(ry); req0_w = 8'(rw); req0_h = 8'(rh); req0_colour = 3'(rc);
    end else begin
      req1_x = 11'(rx); req1_y = 11'(ry); req1_w = 8'(rw); req1_h = 8'(rh); req1_colour = 3'(rc);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("wait_idle_timeout", int'(busy === 1'b0), 1);
  endtask

  // Accepts one command and watches it until done; returns what was observed
  task automatic run_cmd(input vec_t v, output int plots, output int done_cyc,
                         output int fx, output int fy, output int lx, output int ly,
                         output int bad_colour, output int other_done);
    int k;
    plots = 0; done_cyc = -1; fx = -1; fy = -1; lx = -1; ly = -1; bad_colour = 0; other_done = 0;
    @(posedge clock); #1;
    set_req(v.sel, v.rx, v.ry, v.rw, v.rh, v.rc);
    if (v.sel == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
    @(negedge clock);
    check("ready_at_accept", int'(v.sel == 0 ? req0_ready : req1_ready), 1);
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req(v.sel, 0, 0, 9, 9, 0);
    for (k = 1; k < 600 && done_cyc < 0; k++) begin
      @(negedge clock);
      if (plot) begin
        plots++;
        if (fx < 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        if (int'(colour) != v.rc) bad_colour++;
      end
      if ((v.sel == 0 ? done1 : done0) == 1'b1) other_done++;
      if ((v.sel == 0 ? done0 : done1) == 1'b1) done_cyc = k;
    end
    check("done_seen", int'(done_cyc > 0), 1);
    @(negedge clock);
    check("busy_after_done", int'(busy), 0);
  endtask

  vec_t vecs[6];
  int plots, done_cyc, fx, fy, lx, ly, bad_colour, other_done;
  int exp_px[6] = '{10, 11, 12, 10, 11, 12};
  int exp_py[6] = '{20, 20, 20, 21, 21, 21};

  initial begin
    vecs[0] = '{0, 10, 20, 3, 2, 5, 6, 7, 10, 20, 12, 21};
    vecs[1] = '{1, 158, 119, 4, 2, 3, 2, 9, 158, 119, 159, 119};
    vecs[2] = '{0, 0, 0, 0, 5, 1, 0, 1, -1, -1, -1, -1};
    vecs[3] = '{1, 2047, 5, 3, 1, 7, 2, 4, 0, 5, 1, 5};
    vecs[4] = '{0, 5, 5, 1, 1, 2, 1, 2, 5, 5, 5, 5};
    vecs[5] = '{1, 100, 100, 4, 0, 4, 0, 1, -1, -1, -1, -1};

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("reset_x", int'(x), 0);
    check("reset_y", int'(y), 0);
    check("reset_colour", int'(colour), 0);
    check("reset_plot", int'(plot), 0);
    check("reset_done", int'({done0, done1}), 0);
    check("reset_ready", int'({req0_ready, req1_ready}), 0);
`ifdef VGA_RECT_SCHED_CLEAR_ON_RESET_EN
    check("reset_busy", int'(busy), 1);
    begin
      int cnt = 0, bad = 0, sx = -1, sy = -1, ex = -1, ey = -1;
      reset = 1'b0;
      for (int k = 0; k < 20000; k++) begin
        @(negedge clock);
        if (plot) begin
          if (cnt == 0) begin sx = int'(x); sy = int'(y); end
          cnt++;
          ex = int'(x); ey = int'(y);
          if (colour != 3'd0 || req0_ready || req1_ready || !busy) bad++;
        end else if (cnt > 0) begin
          break;
        end else if (req0_ready || req1_ready) begin
          bad++;
        end
      end
      check("clear_count", cnt, 19200);
      check("clear_first", sx * 1000 + sy, 0);
      check("clear_last", ex * 1000 + ey, 159 * 1000 + 119);
      check("clear_violations", bad, 0);
      check("clear_then_idle", int'(busy), 0);
    end
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
`else
    check("reset_busy", int'(busy), 0);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
`endif
    wait_idle(25000);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i], plots, done_cyc, fx, fy, lx, ly, bad_colour, other_done);
      check($sformatf("v%0d_plots", i), plots, vecs[i].exp_plots);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_first", i), fx * 10000 + fy, vecs[i].fx * 10000 + vecs[i].fy);
      check($sformatf("v%0d_last", i), lx * 10000 + ly, vecs[i].lx * 10000 + vecs[i].ly);
      check($sformatf("v%0d_colour", i), bad_colour, 0);
      check($sformatf("v%0d_other_done", i), other_done, 0);
    end

    // pixel-by-pixel walk of the 3x2 rectangle
    @(posedge clock); #1;
    set_req(0, 10, 20, 3, 2, 5);
    req0_valid = 1'b1;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("walk%0d_plot", k), int'(plot), 1);
      check($sformatf("walk%0d_xy", k), int'(x) * 10000 + int'(y), exp_px[k] * 10000 + exp_py[k]);
    end
    @(negedge clock);
    check("walk_done0", int'(done0), 1);
    check("walk_plot_in_done", int'(plot), 0);
    check("walk_hold_x", int'(x), 12);
    wait_idle(10);

    // reset in cycle 3 of a 4x4 draw
    @(posedge clock); #1;
    set_req(0, 20, 20, 4, 4, 6);
    req0_valid = 1'b1;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_plot_before_reset", int'(plot), 1);
    set_req(1, 1, 1, 1, 1, 1);
    req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_plot_async_drop", int'(plot), 0);
    check("mid_ready_in_reset", int'(req1_ready), 0);
    req1_valid = 1'b0;
    begin
      int d0 = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        if (done0) d0++;
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clock);
        if (done0) d0++;
      end
      check("mid_no_done0", d0, 0);
    end
    wait_idle(25000);
    run_cmd('{1, 30, 40, 2, 2, 1, 4, 5, 30, 40, 31, 41}, plots, done_cyc, fx, fy, lx, ly, bad_colour, other_done);
    check("post_reset_plots", plots, 4);
    check("post_reset_done_cycle", done_cyc, 5);
    check("post_reset_last", lx * 10000 + ly, 31 * 10000 + 41);

    // contention from a fresh reset: grants alternate starting with req0
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_idle(25000);
    @(posedge clock); #1;
    set_req(0, 50, 50, 2, 1, 2);
    set_req(1, 60, 60, 2, 1, 3);
    req0_valid = 1'b1; req1_valid = 1'b1;
    begin
      int g[4], gc[4], n = 0, both = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
        @(negedge clock);
        if (req0_ready && req1_ready) both++;
        if (req0_ready) begin g[n] = 0; gc[n] = c; n++; end
        else if (req1_ready) begin g[n] = 1; gc[n] = c; n++; end
      end
      @(posedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("cont_grant_count", n, 4);
      check("cont_both_ready", both, 0);
      if (n == 4) begin
        check("cont_order", g[0] * 1000 + g[1] * 100 + g[2] * 10 + g[3], 101);
        check("cont_gap1", gc[1] - gc[0], 4);
        check("cont_gap2", gc[2] - gc[1], 4);
        check("cont_gap3", gc[3] - gc[2], 4);
      end
    end
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
